// File: rtl/audio_sample_sched.sv
// audio_sample_sched: sample-rate scheduler feeding the audio PWM DAC stage.
//
// Takes samples from two producers and gives src1 (tone) priority over src0
// (demodulator). Samples are buffered in a small FIFO, and one sample is
// released per DIV-cycle sample period.
//
// Ports:
//   clk, RST           clock, synchronous active-high reset
//   enable             playback enable; low stops playback and flushes the FIFO
//   src0_valid/data    demodulator sample; src0_ready when accepted
//   src1_valid/data    tone sample; src1_ready when accepted (wins over src0)
//   sample_out         registered sample presented to the PWM stage
//   sample_tick        one-cycle strobe, aligned with sample_out updates
//   playing            high while in RUN
//   underrun           one-cycle pulse with sample_tick when RUN finds FIFO empty
//   underrun_cnt       saturating underrun count, cleared by RST only
//   fifo_level         current FIFO occupancy, 0..FIFO_DEPTH
module audio_sample_sched #(
    parameter int DATA_W     = 10,
    parameter int DIV        = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int PRIME_LVL  = 4,
    parameter int MIDSCALE   = 512
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          enable,
    input  logic                          src0_valid,
    input  logic [DATA_W-1:0]             src0_data,
    output logic                          src0_ready,
    input  logic                          src1_valid,
    input  logic [DATA_W-1:0]             src1_data,
    output logic                          src1_ready,
    output logic [DATA_W-1:0]             sample_out,
    output logic                          sample_tick,
    output logic                          playing,
    output logic                          underrun,
    output logic [7:0]                    underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int CW = $clog2(DIV);
    localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d, level;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   out_q, out_d, push_data;
    logic                tick_q, tick_d, und_q, und_d;
    logic [7:0]          ucnt_q, ucnt_d;
    logic                full, empty, tick, push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level      = wr_q - rd_q;
    assign full       = level == PW'(FIFO_DEPTH);
    assign empty      = level == '0;
    assign tick       = state_q != IDLE && cnt_q == CW'(DIV - 1);
    assign src1_ready = !full && state_q != IDLE;
    assign src0_ready = src1_ready && !src1_valid;
    assign push       = (src1_valid && src1_ready) || (src0_valid && src0_ready);
    assign push_data  = src1_valid ? src1_data : src0_data;

    assign sample_out   = out_q;
    assign sample_tick  = tick_q;
    assign playing      = state_q == RUN;
    assign underrun     = und_q;
    assign underrun_cnt = ucnt_q;
    assign fifo_level   = level;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        und_d   = 1'b0;
        ucnt_d  = ucnt_q;
        if (!enable) begin
            // Stop wins over everything, including a tick due this cycle.
            state_d = IDLE;
            cnt_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            out_d   = MID;
        end else begin
            cnt_d = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
            wr_d  = wr_q + PW'(push);
            if (state_q == IDLE) begin
                state_d = PRIME;
                wr_d    = '0;
                rd_d    = '0;
                out_d   = MID;
            end else if (state_q == PRIME) begin
                if (tick) begin
                    tick_d = 1'b1;
                    out_d  = MID;
                end
                if (level >= PW'(PRIME_LVL))
                    state_d = RUN;
            end else if (tick) begin
                tick_d = 1'b1;
                // Registered level: a push landing on this tick is not poppable yet.
                if (empty) begin
                    und_d   = 1'b1;
                    ucnt_d  = ucnt_q + {7'd0, ucnt_q != 8'hFF};
                    state_d = PRIME;
                end else begin
                    out_d = mem_q[rd_q[AW-1:0]];
                    rd_d  = rd_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            out_q   <= MID;
            tick_q  <= 1'b0;
            und_q   <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
            und_q   <= und_d;
            ucnt_q  <= ucnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: doc/audio_sample_sched.md
Name: audio_sample_sched

Overview:
Sample-rate scheduler that sits in front of the audio PWM DAC stage. It accepts 10-bit audio samples from two producers: the FM demodulator stream (src0) and the alert/tone generator (src1). It arbitrates between them and buffers samples in a small FIFO. It releases exactly one sample per sample period, together with a one-cycle sample strobe, which the PWM stage uses to restart its ramp counter. It primes the FIFO before playback, detects underruns, and outputs midscale when idle or starved.

Parameters:
DATA_W, 10, sample width (matches the PWM compare range)
DIV, 1024, clk cycles per sample period; must be >= 4
FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and >= 4
PRIME_LVL, 4, FIFO level required before playback starts; 1..FIFO_DEPTH
MIDSCALE, 512, value driven on sample_out while idle or priming

Ports:
clk  in  1  system clock
RST  in  1  synchronous reset, active-high
enable  in  1  playback enable; low = stop and flush
src0_valid  in  1  demodulator sample valid
src0_data  in  DATA_W  demodulator sample
src0_ready  out  1  src0 sample accepted this cycle when valid&ready
src1_valid  in  1  tone sample valid
src1_data  in  DATA_W  tone sample
src1_ready  out  1  src1 sample accepted this cycle when valid&ready
sample_out  out  DATA_W  current sample presented to the PWM stage (registered)
sample_tick  out  1  one-cycle strobe: sample period boundary, sample_out updated
playing  out  1  high in RUN state
underrun  out  1  one-cycle pulse when a tick finds the FIFO empty in RUN
underrun_cnt  out  8  saturating underrun count; cleared by RST only
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values (RST high at a clk edge; overrides everything, including mid-operation): state IDLE, FIFO empty, period counter 0, sample_out=MIDSCALE, sample_tick=0, playing=0, underrun=0, underrun_cnt=0.
- Arbitration is combinational with fixed priority, src1 over src0:
  - src1_ready = !full && state!=IDLE
  - src0_ready = !full && state!=IDLE && !src1_valid
  - At most one push per cycle.
  - "full" is the registered full flag; a same-cycle pop does not free space for a push.
- Period counter:
  - Held at 0 in IDLE.
  - Otherwise counts 0..DIV-1 and wraps.
  - A tick event occurs in the cycle the counter equals DIV-1.
  - sample_tick and the updated sample_out are both registered, so they appear together one cycle after the tick event.
- States:
  - IDLE: sample_out=MIDSCALE, FIFO held flushed, no ticks. When enable=1, go to PRIME next cycle.
  - PRIME: pushes are accepted and ticks are generated. On each tick, sample_out<=MIDSCALE with no pop. Go to RUN when fifo_level >= PRIME_LVL, evaluated on the registered level. The period counter is not reset on this transition.
  - RUN: playing=1. On each tick:
    - If the FIFO is non-empty: pop the head, and sample_out<=head.
    - If empty: sample_out holds its last value, underrun pulses with sample_tick, underrun_cnt increments (saturates at 255), and the state returns to PRIME.
  - Any state with enable=0: go to IDLE next cycle, flush the FIFO, zero the counter, sample_out<=MIDSCALE. Any tick pending in that cycle is dropped.
- Simultaneous push and pop in RUN: both take effect and the level is unchanged.
- Push when full is impossible because ready is low. A push into an empty FIFO on a tick cycle is not visible to that tick's pop; that tick is an underrun.
- fifo_level is exact: 0..FIFO_DEPTH. Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Tick-to-tick spacing is exactly DIV cycles while not in IDLE.

Test Plan:
- Reset/idle: hold RST 3 cycles then release with enable=0 for 2000 cycles -> sample_out=512, sample_tick never asserts, src0_ready=src1_ready=0, fifo_level=0.
- Prime and play: enable=1; push src0 samples 100,200,300,400,500 back-to-back -> state reaches RUN after the 4th push is registered. Subsequent ticks spaced 1024 cycles present 100,200,300,400,500 in order. Every tick before RUN shows 512.
- Arbitration: src0_valid and src1_valid both high with data 0x011/0x3FF while the FIFO has room -> only src1 is accepted (src1_ready=1, src0_ready=0). After src1_valid drops, src0 is accepted the next cycle, giving FIFO order 0x3FF then 0x011.
- Full/backpressure: with DIV=16, push 10 samples continuously into the 8-deep FIFO -> ready drops after the 8th accept, fifo_level=8, no sample is lost or duplicated, and ready reasserts the cycle after the next pop.
- Underrun: in RUN, stop pushing until empty -> the next tick holds the last sample, underrun pulses coincident with sample_tick, underrun_cnt=1, state returns to PRIME, and the following ticks output 512. After 256+ underruns the counter stays at 255.
- Mid-operation stop: drop enable with 5 samples queued -> next cycle IDLE, fifo_level=0, sample_out=512, no further ticks. Re-enable and RST pulse mid-RUN both restart from PRIME/IDLE with an empty FIFO.
